// File: rtl/csr_unit.sv
// Machine-mode CSR execute/storage stage: CSR read-modify-write, trap entry,
// mret and the resulting fetch redirect.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    CSR instruction from issue (valid/ready handshake)
//   rsp_*                    old CSR value / illegal flag (valid/ready handshake)
//   trap_*                   trap entry request with cause, pc and tval
//   mret_valid               return from trap
//   redirect_valid/_pc       one-cycle PC redirect pulse to fetch
module csr_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned HART_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_nowrite,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CYC_W = 2 * XLEN;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] ONES         = '1;
  localparam logic [XLEN-1:0] MASK_ALIGN   = ~XLEN'(3);
  localparam logic [XLEN-1:0] MASK_MSTATUS = XLEN'(32'h88);

  // Shared write-merge: RW -> rs1, RS -> csr|rs1, RC -> csr&~rs1.
  function automatic logic [XLEN-1:0] csr_merge(input logic [XLEN-1:0] csr,
                                                input logic [XLEN-1:0] rs1,
                                                input logic [XLEN-1:0] cm1,
                                                input logic [XLEN-1:0] cm2);
    return ((((csr & cm1) | rs1) & cm2) | (csr & ~rs1 & ~cm2));
  endfunction

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, mcycleh;

  logic [XLEN-1:0] mstatus_rd, rd_val, wmask, cm1, cm2, wr_val;
  logic [CYC_W-1:0] cycle_next;
  logic            hit, wants_write, illegal, accept, do_write;

  // mstatus view: MPP fixed at machine mode, only MIE/MPIE are stored.
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie;
    mstatus_rd[3]     = mie;
  end

  // Address decode: read value and writable mask.
  always_comb begin
    hit   = 1'b1;
    rd_val = '0;
    wmask = '0;
    case (req_addr)
      ADDR_MSTATUS:  begin rd_val = mstatus_rd; wmask = MASK_MSTATUS; end
      ADDR_MTVEC:    begin rd_val = mtvec;      wmask = MASK_ALIGN;   end
      ADDR_MSCRATCH: begin rd_val = mscratch;   wmask = ONES;         end
      ADDR_MEPC:     begin rd_val = mepc;       wmask = MASK_ALIGN;   end
      ADDR_MCAUSE:   begin rd_val = mcause;     wmask = ONES;         end
      ADDR_MTVAL:    begin rd_val = mtval;      wmask = ONES;         end
      ADDR_MCYCLE:   begin rd_val = mcycle;     wmask = ONES;         end
      ADDR_MCYCLEH:  begin rd_val = mcycleh;    wmask = ONES;         end
      ADDR_MHARTID:  rd_val = XLEN'(HART_ID);
      default:       hit = 1'b0;
    endcase
  end

  // Merge-mask selection per op.
  always_comb begin
    cm1 = '0;
    cm2 = ONES;
    case (req_op)
      OP_RS:   cm1 = ONES;
      OP_RC:   cm2 = '0;
      default: ;
    endcase
  end

  // RW always writes; RS/RC write unless the source register is x0.
  assign wants_write = (req_op == OP_RW) || ((req_op != 2'b00) && !req_nowrite);
  // addr[11:10]==11 is the read-only CSR space (covers mhartid).
  assign illegal     = !hit || (req_op == 2'b00) ||
                       (wants_write && (req_addr[11:10] == 2'b11));
  assign req_ready   = !trap_valid && !mret_valid && (!rsp_valid || rsp_ready);
  assign accept      = req_valid && req_ready;
  assign do_write    = accept && !illegal && wants_write;
  assign wr_val      = (rd_val & ~wmask) | (csr_merge(rd_val, req_wdata, cm1, cm2) & wmask);
  assign cycle_next  = {mcycleh, mcycle} + CYC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mie            <= 1'b0;
      mpie           <= 1'b0;
      mtvec          <= '0;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mcycle         <= '0;
      mcycleh        <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // A write to either half suppresses this cycle's increment.
      if (do_write && (req_addr == ADDR_MCYCLE)) begin
        mcycle <= wr_val;
      end else if (do_write && (req_addr == ADDR_MCYCLEH)) begin
        mcycleh <= wr_val;
      end else begin
        {mcycleh, mcycle} <= cycle_next;
      end

      if (do_write) begin
        case (req_addr)
          ADDR_MSTATUS:  begin mie <= wr_val[3]; mpie <= wr_val[7]; end
          ADDR_MTVEC:    mtvec    <= wr_val;
          ADDR_MSCRATCH: mscratch <= wr_val;
          ADDR_MEPC:     mepc     <= wr_val;
          ADDR_MCAUSE:   mcause   <= wr_val;
          ADDR_MTVAL:    mtval    <= wr_val;
          default:       ;
        endcase
      end

      // Trap/mret never coincide with an accepted request (req_ready is low).
      redirect_valid <= 1'b0;
      if (trap_valid) begin
        mepc           <= trap_pc & MASK_ALIGN;
        mcause         <= trap_cause;
        mtval          <= trap_tval;
        mpie           <= mie;
        mie            <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= mtvec & MASK_ALIGN;
      end else if (mret_valid) begin
        mie            <= mpie;
        mpie           <= 1'b1;
        redirect_valid <= 1'b1;
        redirect_pc    <= mepc;
      end

      if (accept) begin
        rsp_valid   <= 1'b1;
        rsp_illegal <= illegal;
        rsp_rdata   <= illegal ? '0 : rd_val;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: table of CSR requests with expected
// responses, checked through a scoreboard queue, plus hand-written trap,
// mret, backpressure and reset sequences.
module tb_csr_unit;

  localparam logic [1:0] OP_IL = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        nw;
    logic [31:0] rdata;
    logic        ill;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic        chk;
    int          id;
  } sb_t;

  logic        clk, rst;
  logic        req_valid, req_ready, req_nowrite;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        trap_valid, mret_valid, redirect_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval, redirect_pc;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];
  sb_t  sb_q[$];
  sb_t  mon_e;

  csr_unit #(.XLEN(32), .HART_ID(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_nowrite(req_nowrite),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_illegal(rsp_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void add(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic nw,
                              input logic [31:0] rdata, input logic ill, input logic chk);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.nw = nw;
    v.rdata = rdata; v.ill = ill; v.chk = chk;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; the expectation is queued on the cycle it is accepted.
  task automatic send(input vec_t v, input int id);
    sb_t e;
    bit  got;
    got = 1'b0;
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
    req_wdata = v.wdata; req_nowrite = v.nw;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.rdata = v.rdata; e.ill = v.ill; e.chk = v.chk; e.id = id;
        sb_q.push_back(e);
        got = 1'b1;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL accept_timeout vec%0d: req_ready stayed 0, expected 1", id);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(tbl[i], i);
  endtask

  // Scoreboard: compare each consumed response with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h with no request outstanding", rsp_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("vec%0d_illegal", mon_e.id), 32'(rsp_illegal), 32'(mon_e.ill));
        if (mon_e.chk) check($sformatf("vec%0d_rdata", mon_e.id), rsp_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // 0..20: read/write, merge, masks, illegal accesses
    add(OP_RW, 12'h340, 32'hDEADBEEF, 0, 32'h00000000, 0, 1);
    add(OP_RS, 12'h340, 32'h00000000, 1, 32'hDEADBEEF, 0, 1);
    add(OP_RS, 12'h340, 32'h00000000, 1, 32'hDEADBEEF, 0, 1);
    add(OP_RW, 12'h340, 32'hF0F0F0F0, 0, 32'hDEADBEEF, 0, 1);
    add(OP_RS, 12'h340, 32'h0000000F, 0, 32'hF0F0F0F0, 0, 1);
    add(OP_RC, 12'h340, 32'hF00000FF, 0, 32'hF0F0F0FF, 0, 1);
    add(OP_RS, 12'h340, 32'h00000000, 1, 32'h00F0F000, 0, 1);
    add(OP_RW, 12'h305, 32'h80000003, 0, 32'h00000000, 0, 1);
    add(OP_RS, 12'h305, 32'h00000000, 1, 32'h80000000, 0, 1);
    add(OP_RS, 12'h300, 32'h00000008, 0, 32'h00001800, 0, 1);
    add(OP_RS, 12'h300, 32'h00000000, 1, 32'h00001808, 0, 1);
    add(OP_RW, 12'hF14, 32'h00000000, 0, 32'h00000000, 1, 1);
    add(OP_RW, 12'h7C0, 32'h00000005, 0, 32'h00000000, 1, 1);
    add(OP_IL, 12'h340, 32'h00001234, 0, 32'h00000000, 1, 1);
    add(OP_RS, 12'hF14, 32'h00000000, 1, 32'h00000005, 0, 1);
    add(OP_RS, 12'hF14, 32'h00000001, 0, 32'h00000000, 1, 1);
    add(OP_RC, 12'h340, 32'h00000000, 1, 32'h00F0F000, 0, 1);
    add(OP_RW, 12'h300, 32'hFFFFFFF7, 0, 32'h00001808, 0, 1);
    add(OP_RW, 12'h300, 32'h00000008, 0, 32'h00001880, 0, 1);
    add(OP_RW, 12'h341, 32'h00002003, 0, 32'h00000000, 0, 1);
    add(OP_RS, 12'h341, 32'h00000000, 1, 32'h00002000, 0, 1);
    // 21..24: state after trap
    add(OP_RS, 12'h341, 32'h00000000, 1, 32'h00001000, 0, 1);
    add(OP_RS, 12'h342, 32'h00000000, 1, 32'h0000000B, 0, 1);
    add(OP_RS, 12'h343, 32'h00000000, 1, 32'h00000055, 0, 1);
    add(OP_RS, 12'h300, 32'h00000000, 1, 32'h00001880, 0, 1);
    // 25: mstatus after mret
    add(OP_RS, 12'h300, 32'h00000000, 1, 32'h00001888, 0, 1);
    // 26..29: 64-bit cycle counter carry
    add(OP_RW, 12'hB00, 32'hFFFFFFFF, 0, 32'h00000000, 0, 0);
    add(OP_RW, 12'hB80, 32'h00000000, 0, 32'h00000000, 0, 1);
    add(OP_RS, 12'hB00, 32'h00000000, 1, 32'hFFFFFFFF, 0, 1);
    add(OP_RS, 12'hB80, 32'h00000000, 1, 32'h00000001, 0, 1);
    // 30: held response; 31: dropped by reset
    add(OP_RS, 12'h340, 32'h00000000, 1, 32'h00F0F000, 0, 1);
    add(OP_RW, 12'h340, 32'h12345678, 0, 32'h00F0F000, 0, 1);
    // 32..34: after reset
    add(OP_RS, 12'hB00, 32'h00000000, 1, 32'h00000000, 0, 1);
    add(OP_RS, 12'h340, 32'h00000000, 1, 32'h00000000, 0, 1);
    add(OP_RS, 12'h300, 32'h00000000, 1, 32'h00001800, 0, 1);

    rst = 1'b1; req_valid = 1'b0; req_op = OP_IL; req_addr = '0; req_wdata = '0;
    req_nowrite = 1'b0; rsp_ready = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_illegal", 32'(rsp_illegal), 0);
    check("reset_redirect_valid", 32'(redirect_valid), 0);
    check("reset_redirect_pc", redirect_pc, 0);

    run(0, 20);

    // Trap with a competing request that must not be accepted.
    req_valid = 1'b1; req_op = OP_RW; req_addr = 12'h340;
    req_wdata = 32'h99999999; req_nowrite = 1'b0;
    trap_valid = 1'b1; trap_cause = 32'h0000000B; trap_pc = 32'h00001002;
    trap_tval = 32'h00000055;
    @(negedge clk);
    check("trap_req_ready", 32'(req_ready), 0);
    tick();
    trap_valid = 1'b0; req_valid = 1'b0;
    check("trap_rsp_valid", 32'(rsp_valid), 0);
    check("trap_redirect_valid", 32'(redirect_valid), 1);
    check("trap_redirect_pc", redirect_pc, 32'h80000000);
    tick();
    check("trap_redirect_pulse", 32'(redirect_valid), 0);
    check("trap_redirect_pc_hold", redirect_pc, 32'h80000000);

    run(21, 24);

    mret_valid = 1'b1;
    @(negedge clk);
    check("mret_req_ready", 32'(req_ready), 0);
    tick();
    mret_valid = 1'b0;
    check("mret_redirect_valid", 32'(redirect_valid), 1);
    check("mret_redirect_pc", redirect_pc, 32'h00001000);
    tick();
    check("mret_redirect_pulse", 32'(redirect_valid), 0);

    run(25, 29);

    // Backpressure: response must hold while rsp_ready is low.
    tick();
    rsp_ready = 1'b0;
    run(30, 30);
    req_valid = 1'b1; req_op = OP_RW; req_addr = 12'h340;
    req_wdata = 32'hAAAAAAAA; req_nowrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_rsp_valid", i), 32'(rsp_valid), 1);
      check($sformatf("hold%0d_rsp_rdata", i), rsp_rdata, 32'h00F0F000);
      check($sformatf("hold%0d_req_ready", i), 32'(req_ready), 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Reset while a response and an mret are pending.
    rsp_ready = 1'b0;
    run(31, 31);
    rst = 1'b1; mret_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rst = 1'b0; mret_valid = 1'b0;
    sb_q.delete();
    check("midreset_rsp_valid", 32'(rsp_valid), 0);
    check("midreset_redirect_valid", 32'(redirect_valid), 0);
    check("midreset_redirect_pc", redirect_pc, 0);
    run(32, 34);

    tick();
    tick();
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
